// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer core and its BCD counter.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        GO    = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; saturates at 9999.
module bcd_counter4
    import reaction_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       at_max
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        carry;

    assign at_max = (cnt_q == {4{BCD_MAX}});

    // Ripple decimal carry from the units digit upward.
    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == BCD_MAX) begin
                    cnt_d[4*i +: 4] = 4'd0;
                end else begin
                    cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_d;
        end
    end

    assign d3 = cnt_q[15:12];
    assign d2 = cnt_q[11:8];
    assign d1 = cnt_q[7:4];
    assign d0 = cnt_q[3:0];

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer control: random wait, GO lamp, millisecond BCD count until react.
//
// state | meaning
// IDLE  | after reset, display 0000
// WAIT  | random delay running, display blank
// GO    | lamp lit, counting ticks in BCD
// DONE  | final count frozen on display
// FAULT | react pressed before GO, display blank
module reaction_timer_core
    import reaction_timer_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int TICK_HZ          = 1000,
    parameter int DELAY_MIN_MS     = 1000,
    parameter int DELAY_RANGE_BITS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       react,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       led_go,
    output logic       early,
    output logic       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DW  = 16;

    state_t          state_q, state_d;
    logic            start_q, react_q;
    logic            start_re, react_re;
    logic [15:0]     lfsr_q;
    logic [PW-1:0]   presc_q;
    logic            tick;
    logic [DW-1:0]   delay_q;
    logic [DW-1:0]   rand_ext;
    logic            enter_timed;
    logic            cnt_clear, cnt_inc, ovf_set;
    logic            ovf_q;
    logic [3:0]      c3, c2, c1, c0;
    logic            at_max;

    // Previous values reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b1;
            react_q  <= 1'b1;
            start_re <= 1'b0;
            react_re <= 1'b0;
        end else begin
            start_q  <= start;
            react_q  <= react;
            start_re <= start & ~start_q;
            react_re <= react & ~react_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    generate
        if (DELAY_RANGE_BITS == 0) begin : g_fixed_delay
            assign rand_ext = '0;
        end else begin : g_rand_delay
            assign rand_ext = DW'(lfsr_q[DELAY_RANGE_BITS-1:0]);
        end
    endgenerate

    assign tick        = (presc_q == PW'(DIV - 1));
    assign enter_timed = (state_d != state_q) && ((state_d == WAIT) || (state_d == GO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (enter_timed || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= '0;
        end else if ((state_d == WAIT) && (state_q != WAIT)) begin
            delay_q <= DW'(DELAY_MIN_MS) + rand_ext;
        end else if ((state_q == WAIT) && tick) begin
            delay_q <= delay_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // react_re outranks a coincident tick in both WAIT and GO.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        ovf_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_re) state_d = WAIT;
            end
            WAIT: begin
                if (react_re) begin
                    state_d = FAULT;
                end else if (tick && (delay_q <= DW'(1))) begin
                    state_d   = GO;
                    cnt_clear = 1'b1;
                end
            end
            GO: begin
                if (react_re) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (at_max) begin
                        state_d = DONE;
                        ovf_set = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE, FAULT: begin
                if (start_re) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (cnt_clear) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

    bcd_counter4 u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .d3     (c3),
        .d2     (c2),
        .d1     (c1),
        .d0     (c0),
        .at_max (at_max)
    );

    // Display is a pure decode of registered state and count.
    always_comb begin
        {digit3, digit2, digit1, digit0} = 16'h0000;
        case (state_q)
            WAIT, FAULT: {digit3, digit2, digit1, digit0} = {4{BLANK_DIGIT}};
            GO, DONE:    {digit3, digit2, digit1, digit0} = {c3, c2, c1, c0};
            default:     {digit3, digit2, digit1, digit0} = 16'h0000;
        endcase
    end

    assign led_go   = (state_q == GO);
    assign early    = (state_q == FAULT);
    assign overflow = ovf_q;

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Control and timing core of the reaction timer. It waits a pseudo-random delay after a start press, then lights the GO LED and counts elapsed milliseconds in 4-digit BCD until the react press. It drives four 4-bit digit codes straight into the per-digit seven-segment decoders; code 4'hF is a blank digit.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1000, count-tick rate. DIV = CLK_HZ/TICK_HZ; must be an integer ≥ 2.
- DELAY_MIN_MS, 1000, minimum random delay in ticks.
- DELAY_RANGE_BITS, 11, random delay span is 0..2^N-1 ticks. 0 gives a fixed delay of DELAY_MIN_MS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start button, active-high, already synchronized and debounced.
- react  in  1  react button, active-high, already synchronized and debounced.
- digit3  out  4  thousands digit, BCD or 4'hF blank.
- digit2  out  4  hundreds digit.
- digit1  out  4  tens digit.
- digit0  out  4  units digit.
- led_go  out  1  high while counting.
- early  out  1  high in FAULT (react pressed before GO).
- overflow  out  1  high when the count saturated at 9999.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, digits 0/0/0/0, led_go 0, early 0, overflow 0, LFSR 16'hACE1, prescaler 0.
- Edge detect: start_re and react_re are single-cycle rising-edge pulses from registered previous values. Previous values reset to 1, so a button held through reset does not trigger.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, advances every clock. It is never 0.
- Prescaler: counts 0..DIV-1. tick pulses one cycle when the count equals DIV-1. It is cleared on entry to WAIT and to GO, so the first tick comes DIV cycles after entry.
- State IDLE: digits show 0000.
  - start_re → WAIT.
- State WAIT: digits blank (4'hF). Delay counter (≥14 bits) loads DELAY_MIN_MS + lfsr[DELAY_RANGE_BITS-1:0] on entry and decrements on each tick.
  - react_re → FAULT. This has priority over expiry in the same cycle.
  - Counter equals 1 and tick → GO.
- State GO: led_go=1. On entry, digits are cleared to 0000 and overflow to 0. Each tick increments the BCD count with decimal carry (9→0 carries upward).
  - react_re → DONE. This has priority over a same-cycle tick: the tick is not applied and the count freezes at its pre-edge value.
  - Tick when the count is 9999 → hold 9999, set overflow=1, go to DONE.
- State DONE: led_go=0. Digits hold the final count; overflow holds.
  - start_re → WAIT.
- State FAULT: early=1, digits blank.
  - start_re → WAIT, clearing early.
- react_re in IDLE or DONE, and start_re in WAIT or GO, are ignored.
- Simultaneous start_re and react_re: each state acts only on the edge it listens to.
- Reset mid-operation returns immediately to the reset values.
- Outputs are registered. A state transition is visible on outputs the cycle after the triggering edge pulse. Edge pulses lag the input by one cycle, so the total is 2 cycles from input rise.

Decomposition:
- Package reaction_timer_pkg: state enum (IDLE, WAIT, GO, DONE, FAULT), BLANK_DIGIT = 4'hF, BCD_MAX digit constant 4'd9, LFSR_SEED = 16'hACE1.
- Sub-module bcd_counter4: synchronous clear, increment enable, 4 BCD digit outputs, and an at_max flag (count equals 9999). It holds its value at 9999.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DELAY_MIN_MS=5, DELAY_RANGE_BITS=0.
1. Reset, then start pulse:
   - WAIT blanks the digits 2 cycles later.
   - led_go rises 50 cycles after WAIT entry.
   - Digits read 0000 at GO entry.
2. In GO, press react after 37 ticks:
   - State DONE, digits 0/0/3/7, led_go=0.
   - Held for 200 further cycles.
3. React rise in WAIT:
   - early=1, digits all 4'hF, led_go never asserts.
   - Next start clears early and re-enters WAIT.
4. React edge pulse coincident with a tick at count 0019:
   - Frozen display is 0019, not 0020.
5. Preload the counter to 9998 via force (or let it run), then two ticks:
   - Digits 9/9/9/9, overflow=1, state DONE.
   - Next start → WAIT, and GO entry clears overflow.
6. Assert rst_n=0 asynchronously mid-GO:
   - Outputs go to 0000/led_go 0/early 0/overflow 0 without a clock edge.
   - Holding start high through reset release produces no WAIT entry.
